// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code consumers.
// Holds the monitor FSM state encoding, error ceiling and index-width helper.
package johnson_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } mon_state_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Bits needed to index all 2*w legal states of a w-bit Johnson code.
    function automatic int idx_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code decoder: maps an MSB-first-fill code to its index.
// Ports: CODE (in, WIDTH) -> legal (out, 1), idx (out, IW; 0 when not legal).
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] CODE,
    output logic             legal,
    output logic [IW-1:0]    idx
);

    // Code word for index k: k<=WIDTH fills ones from the MSB down,
    // beyond that zeros fill from the MSB down over an all-ones word.
    function automatic logic [WIDTH-1:0] jcode(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH)
                c[i] = (i >= WIDTH - k);
            else
                c[i] = (i < 2 * WIDTH - k);
        end
        return c;
    endfunction

    always_comb begin
        legal = 1'b0;
        idx   = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (CODE == jcode(k)) begin
                legal = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Receive-side Johnson sequence monitor: decodes samples, tracks lock, counts errors.
// Ports: CLK, CLR (async high), EN, CODE in; STATE_IDX, IDX_VALID, ILLEGAL,
// SKIP, STALL, LOCKED, ERR_COUNT out. All outputs registered, 1-cycle latency.
module johnson_seq_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int IW       = idx_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [WIDTH-1:0] CODE,
    output logic [IW-1:0]    STATE_IDX,
    output logic             IDX_VALID,
    output logic             ILLEGAL,
    output logic             SKIP,
    output logic             STALL,
    output logic             LOCKED,
    output logic [7:0]       ERR_COUNT
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_CNT);

    mon_state_t    state;
    logic [3:0]    run;
    logic [IW-1:0] prev_idx;

    logic          legal;
    logic [IW-1:0] idx;
    logic [IW-1:0] succ;
    logic [3:0]    run_nxt;
    logic [7:0]    err_inc;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_dec (
        .CODE  (CODE),
        .legal (legal),
        .idx   (idx)
    );

    // Successor wraps explicitly so non-power-of-two state counts work.
    assign succ    = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
    assign run_nxt = run + 4'd1;
    assign err_inc = (ERR_COUNT == ERR_MAX) ? ERR_MAX : ERR_COUNT + 8'd1;

    // The reference index is exactly the last legal sample.
    assign STATE_IDX = prev_idx;
    assign LOCKED    = (state == LOCK);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= HUNT;
            run       <= '0;
            prev_idx  <= '0;
            IDX_VALID <= 1'b0;
            ILLEGAL   <= 1'b0;
            SKIP      <= 1'b0;
            STALL     <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            IDX_VALID <= 1'b0;
            ILLEGAL   <= 1'b0;
            SKIP      <= 1'b0;
            STALL     <= 1'b0;
            if (EN) begin
                if (!legal) begin
                    ILLEGAL   <= 1'b1;
                    ERR_COUNT <= err_inc;
                    state     <= HUNT;
                    run       <= '0;
                end else begin
                    IDX_VALID <= 1'b1;
                    prev_idx  <= idx;
                    case (state)
                        HUNT: begin
                            // No reference yet, so nothing counts as repeat/skip.
                            run   <= 4'd1;
                            state <= (LOCK_N == 4'd1) ? LOCK : TRACK;
                        end
                        default: begin
                            if (idx == prev_idx) begin
                                STALL <= 1'b1;
                            end else if (idx == succ) begin
                                if (state == TRACK) begin
                                    run <= run_nxt;
                                    if (run_nxt >= LOCK_N)
                                        state <= LOCK;
                                end
                            end else begin
                                SKIP      <= 1'b1;
                                ERR_COUNT <= err_inc;
                                state     <= TRACK;
                                run       <= 4'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed self-checking bench for johnson_seq_monitor (WIDTH=4, LOCK_CNT=3).
// Pulse vector order: {IDX_VALID, ILLEGAL, SKIP, STALL}.
module tb_johnson_seq_monitor;

    logic       CLK;
    logic       CLR;
    logic       EN;
    logic [3:0] CODE;
    logic [2:0] STATE_IDX;
    logic       IDX_VALID;
    logic       ILLEGAL;
    logic       SKIP;
    logic       STALL;
    logic       LOCKED;
    logic [7:0] ERR_COUNT;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_VALID = 4'b1000;
    localparam logic [3:0] P_ILL   = 4'b0100;
    localparam logic [3:0] P_SKIP  = 4'b1010;
    localparam logic [3:0] P_STALL = 4'b1001;

    johnson_seq_monitor #(
        .WIDTH    (4),
        .LOCK_CNT (3)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .EN        (EN),
        .CODE      (CODE),
        .STATE_IDX (STATE_IDX),
        .IDX_VALID (IDX_VALID),
        .ILLEGAL   (ILLEGAL),
        .SKIP      (SKIP),
        .STALL     (STALL),
        .LOCKED    (LOCKED),
        .ERR_COUNT (ERR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [2:0] idx,
                      input logic [3:0] p, input logic lk,
                      input logic [7:0] e);
        chk({tag, "_idx"}, 32'(STATE_IDX), 32'(idx));
        chk({tag, "_pulse"}, 32'({IDX_VALID, ILLEGAL, SKIP, STALL}), 32'(p));
        chk({tag, "_lock"}, 32'(LOCKED), 32'(lk));
        chk({tag, "_err"}, 32'(ERR_COUNT), 32'(e));
    endtask

    // Present one sample on the next rising edge, then settle past it.
    task automatic samp(input logic [3:0] c);
        EN   = 1'b1;
        CODE = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        EN = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_clr();
        EN  = 1'b0;
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
    endtask

    initial begin
        CLR  = 1'b1;
        EN   = 1'b0;
        CODE = 4'b0000;
        #1;
        st("rst", 3'd0, P_NONE, 1'b0, 8'd0);
        @(posedge CLK);
        #1;
        CLR = 1'b0;

        // Lock-in
        samp(4'b0000); st("lk0", 3'd0, P_VALID, 1'b0, 8'd0);
        samp(4'b1000); st("lk1", 3'd1, P_VALID, 1'b0, 8'd0);
        samp(4'b1100); st("lk2", 3'd2, P_VALID, 1'b1, 8'd0);
        samp(4'b1110); st("lk3", 3'd3, P_VALID, 1'b1, 8'd0);

        // Wrap through 7 -> 0
        samp(4'b1111); st("wr4", 3'd4, P_VALID, 1'b1, 8'd0);
        samp(4'b0111); st("wr5", 3'd5, P_VALID, 1'b1, 8'd0);
        samp(4'b0011); st("wr6", 3'd6, P_VALID, 1'b1, 8'd0);
        samp(4'b0001); st("wr7", 3'd7, P_VALID, 1'b1, 8'd0);
        samp(4'b0000); st("wr0", 3'd0, P_VALID, 1'b1, 8'd0);
        samp(4'b1000); st("wr1", 3'd1, P_VALID, 1'b1, 8'd0);

        // Illegal while locked
        samp(4'b1010); st("ill", 3'd1, P_ILL, 1'b0, 8'd1);
        samp(4'b0111); st("hunt", 3'd5, P_VALID, 1'b0, 8'd1);
        samp(4'b0011); st("tr2", 3'd6, P_VALID, 1'b0, 8'd1);
        samp(4'b0001); st("tr3", 3'd7, P_VALID, 1'b1, 8'd1);
        samp(4'b0000); st("lkA", 3'd0, P_VALID, 1'b1, 8'd1);
        samp(4'b1000); st("lkB", 3'd1, P_VALID, 1'b1, 8'd1);

        // EN gating while locked
        idle(2);
        st("gate", 3'd1, P_NONE, 1'b1, 8'd1);

        // Stall then skip, then re-lock
        samp(4'b1000); st("stall", 3'd1, P_STALL, 1'b1, 8'd1);
        samp(4'b1110); st("skip", 3'd3, P_SKIP, 1'b0, 8'd2);
        samp(4'b1111); st("rl1", 3'd4, P_VALID, 1'b0, 8'd2);
        samp(4'b0111); st("rl2", 3'd5, P_VALID, 1'b1, 8'd2);

        // Saturation
        for (int i = 0; i < 300; i++) samp(4'b0101);
        st("sat", 3'd5, P_ILL, 1'b0, 8'd255);
        idle(3);
        st("satgate", 3'd5, P_NONE, 1'b0, 8'd255);

        // Build locked state with ERR_COUNT=5
        pulse_clr();
        st("clr2", 3'd0, P_NONE, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) samp(4'b1010);
        samp(4'b0000);
        samp(4'b1000);
        samp(4'b1100);
        st("pre", 3'd2, P_VALID, 1'b1, 8'd5);

        // Async CLR between edges, held across an EN=1 edge
        #2;
        CLR  = 1'b1;
        EN   = 1'b1;
        CODE = 4'b1000;
        #1;
        st("async", 3'd0, P_NONE, 1'b0, 8'd0);
        @(posedge CLK);
        #1;
        st("clren", 3'd0, P_NONE, 1'b0, 8'd0);
        CLR = 1'b0;
        samp(4'b1000); st("resume", 3'd1, P_VALID, 1'b0, 8'd0);
        EN = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/johnson_seq_monitor.md
# johnson_seq_monitor

Receive-side companion to the 4-bit Johnson counter: samples a Johnson-coded count word, decodes it to a binary state index and checks that successive samples follow the legal Johnson sequence. The block tracks sequence lock and keeps a saturating error count. It sits on the consumer side of any Johnson-count bus, for example a counter output crossing to another block, or the input to a phase/sequence checker.

## Interface
- WIDTH, 4: Johnson code width. Gives 2*WIDTH legal states. Minimum 2.
- LOCK_CNT, 3: number of consecutive in-sequence samples required to declare lock. Range 1..15.
- IW, $clog2(2*WIDTH): derived index width. Not to be overridden.
- CLK  in  1  clock. All state changes on its rising edge.
- CLR  in  1  reset. Asynchronous, active-high.
- EN  in  1  sample strobe. CODE is sampled on a rising edge of CLK when EN=1.
- CODE  in  WIDTH  Johnson-coded input word.
- STATE_IDX  out  IW  decoded index of the last legal sample.
- IDX_VALID  out  1  one-cycle pulse: the sample was legal and STATE_IDX was updated.
- ILLEGAL  out  1  one-cycle pulse: the sample was not one of the 2*WIDTH legal codes.
- SKIP  out  1  one-cycle pulse: the sample was legal but neither the successor of the previous legal sample nor a repeat of it.
- STALL  out  1  one-cycle pulse: the sample was a legal repeat of the previous legal sample.
- LOCKED  out  1  level: the sequence is locked.
- ERR_COUNT  out  8  saturating error counter.

## Operation
- **Legal codes, MSB-first fill:**
  - Index k in 0..WIDTH: the top k bits are 1 and the rest are 0.
  - Index k in WIDTH+1..2*WIDTH-1: the top k-WIDTH bits are 0 and the rest are 1.
  - For WIDTH=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- **Successor rule:** the successor of index k is (k+1) mod 2*WIDTH, so 2*WIDTH-1 wraps to 0 and this is not a SKIP.
- **FSM states:** HUNT, TRACK, LOCK. There is an internal run counter (4 bits) and a previous-index register.
  - **HUNT, legal sample:** go to TRACK with run=1. If LOCK_CNT=1, go directly to LOCK.
  - **HUNT, illegal sample:** stay in HUNT.
  - **TRACK, successor:** run+1. Go to LOCK when run reaches LOCK_CNT.
  - **TRACK or LOCK, STALL:** state and run are unchanged.
  - **TRACK or LOCK, SKIP:** go to TRACK with run=1. The new index becomes the reference.
  - **TRACK or LOCK, ILLEGAL:** go to HUNT with run=0. The previous-index register is unchanged.
- **LOCKED:** equals (state==LOCK).
- **ERR_COUNT:** +1 on every ILLEGAL (any state) and on every SKIP. It saturates at 255 and never wraps.
- **EN=0:** nothing is sampled. All pulses are 0 the next cycle. STATE_IDX, LOCKED, ERR_COUNT and the FSM state are held.
- **Simultaneous CLR and EN:** CLR wins. The sample is discarded.

## Timing
- All outputs are registered. The outputs for a sample taken at edge N are visible after edge N and stay valid until edge N+1. Latency is 1 cycle.
- Pulses are asserted for exactly one cycle per sample. Back-to-back EN produces one pulse set per cycle.
- At most one of IDX_VALID+STALL, ILLEGAL and SKIP applies per sample:
  - A STALL sample also asserts IDX_VALID.
  - A SKIP sample also asserts IDX_VALID.
  - An ILLEGAL sample never asserts IDX_VALID.
- LOCKED rises in the same cycle as the IDX_VALID of the LOCK_CNT-th in-sequence sample. It falls in the same cycle as the ILLEGAL or SKIP pulse.
- **Reset (CLR=1, asynchronous, takes effect immediately, including mid-sequence):**
  - STATE_IDX=0
  - all pulses=0
  - LOCKED=0
  - ERR_COUNT=0
  - FSM in HUNT, run=0, previous index=0
  - Normal operation resumes on the first rising edge after CLR is deasserted.

## Structure
- **Shared package johnson_pkg:**
  - FSM state enum (HUNT, TRACK, LOCK).
  - ERR_MAX=8'd255.
  - A constant function for the index width.
- **Sub-module johnson_code_decode:** purely combinational, parameter WIDTH. Input is CODE; outputs are legal and idx[IW-1:0]. It is shared with future Johnson-code consumers.
- The FSM, counters and output registers live in johnson_seq_monitor.

## Test plan
All scenarios use WIDTH=4 and LOCK_CNT=3.
- **Lock-in:** CLR pulse, then EN=1 with 0000, 1000, 1100, 1110 → STATE_IDX=0,1,2,3, IDX_VALID every cycle. LOCKED rises with idx=2 and stays high. ERR_COUNT=0.
- **Wrap:** while locked, feed 0011, 0001, 0000, 1000 → idx 6, 7, 0, 1. No SKIP. LOCKED stays 1.
- **Illegal while locked:** feed 1010 → ILLEGAL=1, IDX_VALID=0, STATE_IDX held, LOCKED→0, ERR_COUNT=1. Then 0000 → HUNT→TRACK.
- **Skip and stall:** locked at 1000, feed 1000 → STALL=1, LOCKED stays 1. Then feed 1110 → SKIP=1, idx=3, LOCKED→0, ERR_COUNT+1. Two further successors (1111, 0111) re-lock.
- **Saturation and EN gating:** 300 cycles of 0101 → ERR_COUNT=255 and held. EN=0 cycles insert no pulses and leave all state unchanged.
- **Async reset mid-sequence:** assert CLR between clock edges while locked with ERR_COUNT=5 → all outputs 0 before the next edge. A CLR coinciding with EN=1 at 1000 leaves STATE_IDX=0 and IDX_VALID=0.
